// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder/subtractor among N requesters.
// Each granted operation runs IDLE -> CALC -> DONE, so one result is produced every 3 cycles.
module adder_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     a_i,
    input  logic [N*WIDTH-1:0]     b_i,
    input  logic [N-1:0]           sub_i,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           done,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   owner,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic                   overflow
);

    localparam int unsigned OW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [OW-1:0]    r_ptr, w_ptr_nxt;
    logic [OW-1:0]    r_owner, w_owner_nxt;
    logic [N-1:0]     r_gnt, w_gnt_nxt;
    logic [N-1:0]     r_done, w_done_nxt;
    logic             r_busy, w_busy_nxt;
    logic [WIDTH-1:0] r_opa, w_opa_nxt;
    logic [WIDTH-1:0] r_opb, w_opb_nxt;
    logic             r_op, w_op_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_overflow, w_overflow_nxt;

    logic             w_found;
    logic [OW-1:0]    w_win;
    int unsigned      w_idx;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;

    // Rotating-priority search: first set req bit at or above r_ptr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && req[OW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = OW'(w_idx);
            end
        end
    end

    // Shared adder; subtract is A + ~B + 1 so carry-out means "no borrow".
    always_comb begin
        w_bop = r_op ? ~r_opb : r_opb;
        w_sum = {1'b0, r_opa} + {1'b0, w_bop} + {{WIDTH{1'b0}}, r_op};
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_gnt_nxt      = '0;
        w_done_nxt     = '0;
        w_busy_nxt     = r_busy;
        w_opa_nxt      = r_opa;
        w_opb_nxt      = r_opb;
        w_op_nxt       = r_op;
        w_result_nxt   = r_result;
        w_carry_nxt    = r_carry;
        w_overflow_nxt = r_overflow;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_CALC;
                    w_owner_nxt = w_win;
                    w_gnt_nxt   = N'(1) << w_win;
                    w_busy_nxt  = 1'b1;
                    w_opa_nxt   = a_i[w_win*WIDTH +: WIDTH];
                    w_opb_nxt   = b_i[w_win*WIDTH +: WIDTH];
                    w_op_nxt    = sub_i[w_win];
                end
            end
            S_CALC: begin
                w_state_nxt    = S_DONE;
                w_result_nxt   = w_sum[WIDTH-1:0];
                w_carry_nxt    = w_sum[WIDTH];
                w_overflow_nxt = (r_opa[WIDTH-1] == w_bop[WIDTH-1]) &&
                                 (w_sum[WIDTH-1] != r_opa[WIDTH-1]);
                w_done_nxt     = N'(1) << r_owner;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = (r_owner == OW'(N-1)) ? '0 : r_owner + OW'(1);
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_busy     <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_op       <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_opa      <= w_opa_nxt;
            r_opb      <= w_opb_nxt;
            r_op       <= w_op_nxt;
            r_result   <= w_result_nxt;
            r_carry    <= w_carry_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign busy     = r_busy;
    assign owner    = r_owner;
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: stimulus queues expected grants/completions,
// a negedge monitor pops and compares whenever gnt or done is presented.
module tb_adder_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       req = '0;
    logic [N*WIDTH-1:0] a_i = '0;
    logic [N*WIDTH-1:0] b_i = '0;
    logic [N-1:0]       sub_i = '0;
    logic [N-1:0]       gnt;
    logic [N-1:0]       done;
    logic               busy;
    logic [1:0]         owner;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               overflow;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        c;
        logic        o;
    } exp_t;

    int   gnt_q[$];
    exp_t done_q[$];
    int   checks = 0;
    int   errors = 0;

    adder_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .reset(reset), .req(req), .a_i(a_i), .b_i(b_i), .sub_i(sub_i),
        .gnt(gnt), .done(done), .busy(busy), .owner(owner), .result(result),
        .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented grant/completion against the queued expectation.
    exp_t m_e;
    int   m_g;
    always @(negedge clk) begin
        if (gnt != 0) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_gnt", 64'(gnt), 64'(0));
            end else begin
                m_g = gnt_q.pop_front();
                check("gnt_onehot", 64'(gnt), 64'(1) << m_g);
                check("gnt_owner", 64'(owner), 64'(m_g));
            end
        end
        if (done != 0) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                m_e = done_q.pop_front();
                check("done_onehot", 64'(done), 64'(1) << m_e.idx);
                check("done_result", 64'(result), 64'(m_e.res));
                check("done_carry", 64'(carry), 64'(m_e.c));
                check("done_overflow", 64'(overflow), 64'(m_e.o));
            end
        end
        if ((gnt & done) != 0) begin
            check("gnt_done_overlap", 64'(gnt & done), 64'(0));
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_bit(input string name, input int idx, input logic want_done, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((want_done ? done[idx] : gnt[idx]) !== 1'b1) && cyc < 20);
        if ((want_done ? done[idx] : gnt[idx]) !== 1'b1)
            check({name, "_timeout"}, 64'(cyc), 64'(0));
    endtask

    task automatic do_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] er, input logic ec, input logic eo);
        int cyc;
        int bcnt;
        exp_t e;
        @(negedge clk);
        a_i[idx*WIDTH +: WIDTH] = a;
        b_i[idx*WIDTH +: WIDTH] = b;
        sub_i[idx] = s;
        req = 4'(1) << idx;
        e.idx = idx; e.res = er; e.c = ec; e.o = eo;
        gnt_q.push_back(idx);
        done_q.push_back(e);
        bcnt = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) bcnt++;
        end while (gnt[idx] !== 1'b1 && cyc < 20);
        check({tag, "_gnt_latency"}, 64'(cyc), 64'(1));
        req = '0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) bcnt++;
        end while (done[idx] !== 1'b1 && cyc < 20);
        check({tag, "_done_latency"}, 64'(cyc), 64'(1));
        repeat (2) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
        end
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(2));
        check({tag, "_result_held"}, 64'(result), 64'(er));
    endtask

    initial begin
        int   cyc;
        int   last;
        int   nd;
        int   ng;
        int   w;
        exp_t e;

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_carry", 64'(carry), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));

        do_op("add_5_3",   0, 32'd5,          32'd3, 1'b0, 32'd8,          1'b0, 1'b0);
        do_op("add_wrap",  1, 32'hFFFF_FFFF,  32'd1, 1'b0, 32'd0,          1'b1, 1'b0);
        do_op("sub_ovf",   2, 32'h8000_0000,  32'd1, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1);
        do_op("sub_borrow",3, 32'd3,          32'd5, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0);

        // Fairness: all four requesting from ptr=0; operands give results 1,12,23,34
        reset_dut();
        a_i = {32'd31, 32'd21, 32'd11, 32'd1};
        b_i = {32'd3,  32'd2,  32'd1,  32'd0};
        sub_i = '0;
        for (int i = 0; i < 7; i++) begin
            w = i % 4;
            gnt_q.push_back(w);
            e.idx = w; e.c = 1'b0; e.o = 1'b0;
            e.res = (w == 0) ? 32'd1 : (w == 1) ? 32'd12 : (w == 2) ? 32'd23 : 32'd34;
            done_q.push_back(e);
        end
        @(negedge clk);
        req = 4'b1111;
        nd = 0; cyc = 0; last = 0;
        while (nd < 7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done != 0) begin
                if (nd > 0) check("done_period", 64'(cyc - last), 64'(3));
                last = cyc;
                nd++;
            end
        end
        if (nd < 7) check("fair_timeout", 64'(nd), 64'(7));

        // Requester 2 just completed: next winners must be 1 then 2
        req = 4'b0110;
        gnt_q.push_back(1);
        gnt_q.push_back(2);
        e.idx = 1; e.res = 32'd12; done_q.push_back(e);
        e.idx = 2; e.res = 32'd23; done_q.push_back(e);
        ng = 0;
        while (ng < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (gnt != 0) ng++;
            if (done != 0) begin
                check("done_period", 64'(cyc - last), 64'(3));
                last = cyc;
                nd++;
            end
        end
        req = '0;
        while (nd < 9 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done != 0) begin
                check("done_period", 64'(cyc - last), 64'(3));
                last = cyc;
                nd++;
            end
        end
        if (nd < 9) check("fair2_timeout", 64'(nd), 64'(9));

        // Reset during CALC of an operation from requester 2 (ptr was 3)
        @(negedge clk);
        req = 4'b0100;
        gnt_q.push_back(2);
        wait_bit("abort_gnt", 2, 1'b0, cyc);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_result", 64'(result), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_carry", 64'(carry), 64'(0));
        check("abort_owner", 64'(owner), 64'(0));

        req = 4'b1010;
        gnt_q.push_back(1);
        e.idx = 1; e.res = 32'd12; e.c = 1'b0; e.o = 1'b0;
        done_q.push_back(e);
        wait_bit("post_rst_gnt", 1, 1'b0, cyc);
        req = '0;
        wait_bit("post_rst_done", 1, 1'b1, cyc);

        repeat (4) @(negedge clk);
        check("gnt_q_empty", 64'(gnt_q.size()), 64'(0));
        check("done_q_empty", 64'(done_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer sharing one WIDTH-bit adder/subtractor among N requesters. It sits between the requesting units and the single adder datapath. It grants one requester at a time, latches that requester's operands and operation, runs one add/subtract, and returns the registered result with a one-cycle completion pulse to the owner. Throughput is one operation per 3 cycles; arbitration is fair (rotating priority).

## Interface
- WIDTH, 32, operand/result width in bits
- N, 4, number of requesters (2..8)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  N  request per requester; bit i high = requester i wants an operation
- a_i  in  N*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH]
- b_i  in  N*WIDTH  packed operand B, same packing
- sub_i  in  N  operation select per requester: 1 = A−B, 0 = A+B
- gnt  out  N  registered one-hot grant, high for exactly one cycle
- done  out  N  registered one-hot completion pulse, high for exactly one cycle
- busy  out  1  high whenever state ≠ IDLE
- owner  out  $clog2(N)  index of the current/last granted requester
- result  out  WIDTH  sum/difference, held until the next completion
- carry  out  1  adder carry-out; for subtract, 1 = no borrow
- overflow  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE → CALC → DONE → IDLE.
- **IDLE**
  - If req ≠ 0, select the winner w: the first set req bit searching upward from ptr, wrapping modulo N.
  - At the next edge:
    - state ← CALC, owner ← w, gnt[w] ← 1.
    - Latch opa ← a_i[w], opb ← b_i[w], op ← sub_i[w].
  - If req = 0, stay in IDLE with all pulses low.
- **CALC**
  - gnt is high during this cycle only.
  - At the next edge:
    - result ← opa + (op ? ~opb : opb) + op, truncated to WIDTH.
    - carry ← bit WIDTH of the WIDTH+1-bit sum.
    - overflow ← (opa[MSB] == b'[MSB]) && (result[MSB] ≠ opa[MSB]), where b' is the inverted or plain opb.
    - done[owner] ← 1, state ← DONE.
- **DONE**
  - done is high during this cycle only.
  - At the next edge: state ← IDLE, ptr ← (owner+1) mod N, done ← 0.
- req is sampled only in IDLE. A requester that keeps req high through DONE is treated as issuing a new request; it is served again only after every other active requester ahead of it in rotation.
- Operands are captured only at the IDLE→CALC edge. Later changes on a_i/b_i/sub_i do not affect the operation in flight.
- A requester dropping req after it has been granted does not cancel the operation.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, owner = 0.
  - gnt = 0, done = 0, busy = 0.
  - result = 0, carry = 0, overflow = 0.
- Latency: req sampled high in IDLE at edge k → gnt high in cycle k+1 → done and result valid in cycle k+2 → ready to arbitrate again in cycle k+3.
- result, carry and overflow change only on the CALC→DONE edge. They are stable from the cycle done rises until the next done.
- gnt and done are never high at the same time. Each has at most one bit set.
- Simultaneous requests: exactly one winner per round, chosen by ptr. No requester starves; worst-case wait is N operations (3N cycles).
- Reset asserted in any state: the next edge forces the reset values. An operation in flight is abandoned and no done is issued for it. ptr returns to 0.

## Test plan
- Single request: reset, then req=0001, a=5, b=3, sub=0.
  - Required: gnt=0001 one cycle later, then done=0001 with result=8, carry=0, overflow=0.
  - busy high for exactly 2 cycles.
- Carry/wrap: a=0xFFFFFFFF, b=1, add.
  - Required: result=0, carry=1, overflow=0.
- Subtract with overflow: a=0x80000000, b=1, sub=1.
  - Required: result=0x7FFFFFFF, carry=1, overflow=1.
- Subtract with borrow: a=3, b=5, sub=1.
  - Required: result=0xFFFFFFFE, carry=0, overflow=0.
- Fairness: req=1111 held continuously after reset.
  - Required grant order 0,1,2,3,0; done pulses every 3 cycles.
  - Then, after requester 2 is served, set req=0110: the next grant is 1, then 2.
- Reset mid-operation: assert reset in the CALC cycle.
  - Required: no done pulse; result=0, busy=0, and ptr back to 0.
  - A following req=1010 grants requester 1 first.
